// File: rtl/project_pwm_peripheral_pkg.sv
// Shared types and constants for the PWM peripheral config controller.
// Frame FSM states, register field codes and address decode helper.
package project_pwm_peripheral_pkg;

    typedef enum logic [1:0] {
        S_ADDR   = 2'd0,
        S_LO     = 2'd1,
        S_HI     = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] FLD_PERIOD = 2'd0;
    localparam logic [1:0] FLD_CMPA   = 2'd1;
    localparam logic [1:0] FLD_CMPB   = 2'd2;
    localparam logic [1:0] FLD_PHASE  = 2'd3;

    localparam logic [4:0] CTRL_CH = 5'd31;
    localparam int         IMM_BIT = 7;

    function automatic logic is_ctrl(input logic [7:0] a);
        return (a[6:2] == CTRL_CH) && (a[1:0] == FLD_PERIOD);
    endfunction

    function automatic logic addr_valid(input logic [7:0] a, input int n_ch);
        return (int'(a[6:2]) < n_ch) || is_ctrl(a);
    endfunction

endpackage

// File: rtl/project_pwm_peripheral_shadow_reg.sv
// One channel's shadow/active field registers and pending flag.
// Shadow is copied to active on the period-boundary update strobe.
module project_pwm_peripheral_shadow_reg
    import project_pwm_peripheral_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       fld,
    input  logic [15:0]      data,
    input  logic             imm,
    input  logic             update,
    output logic [3:0][15:0] o_active,
    output logic             o_pending
);

    logic [3:0][15:0] shadow_q, shadow_d;
    logic [3:0][15:0] active_q, active_d;
    logic             pending_q, pending_d;

    // Update runs first so a same-edge commit re-arms pending for the next strobe.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (update && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (we) begin
            shadow_d[fld] = data;
            if (imm) begin
                active_d[fld] = data;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign o_active  = active_q;
    assign o_pending = pending_q;

endmodule

// File: rtl/project_pwm_peripheral_config_ctrl.sv
// Byte-serial 3-byte frame receiver feeding per-channel shadow registers.
// Active values move on the master period strobe, or at once for IMM/disabled.
module project_pwm_peripheral_config_ctrl
    import project_pwm_peripheral_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [7:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_update,
    output logic [16*N_CH-1:0]  o_period,
    output logic [16*N_CH-1:0]  o_compare_a,
    output logic [16*N_CH-1:0]  o_compare_b,
    output logic [16*N_CH-1:0]  o_phase,
    output logic                o_en,
    output logic [1:0]          o_mode,
    output logic                o_sync_en,
    output logic [N_CH-1:0]     o_pending,
    output logic                o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      lo_q, lo_d;
    logic [7:0]      hi_q, hi_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic            err_q, err_d;
    logic            ready_q;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            accept;
    logic            commit;
    logic            ch_ok;
    logic            imm_w;
    logic [15:0]     wdata;

    assign o_ready = ready_q && (state_q != S_COMMIT);
    assign accept  = i_valid && o_ready;
    assign commit  = (state_q == S_COMMIT);
    assign ch_ok   = int'(addr_q[6:2]) < N_CH;
    assign imm_w   = addr_q[IMM_BIT] || !ctrl_q[0];
    assign wdata   = {hi_q, lo_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_ADDR: begin
                tmo_d = '0;
                if (accept) begin
                    addr_d  = i_data;
                    err_d   = !addr_valid(i_data, N_CH);
                    state_d = S_LO;
                end
            end
            S_LO, S_HI: begin
                if (accept) begin
                    tmo_d = '0;
                    if (state_q == S_LO) begin
                        lo_d    = i_data;
                        state_d = S_HI;
                    end else begin
                        hi_d    = i_data;
                        state_d = S_COMMIT;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    state_d = S_ADDR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_ADDR;
                if (is_ctrl(addr_q)) begin
                    ctrl_d = lo_q[3:0];
                end
            end
            default: state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_ADDR;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ctrl_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
            ready_q <= 1'b1;
            tmo_q   <= tmo_d;
        end
    end

    assign o_en      = ctrl_q[0];
    assign o_mode    = ctrl_q[2:1];
    assign o_sync_en = ctrl_q[3];
    assign o_err     = err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [3:0][15:0] act;
        logic             we;

        assign we = commit && ch_ok && (addr_q[6:2] == 5'(k));

        project_pwm_peripheral_shadow_reg u_reg (
            .clk       (i_clk),
            .rst_n     (i_reset),
            .we        (we),
            .fld       (addr_q[1:0]),
            .data      (wdata),
            .imm       (imm_w),
            .update    (i_update),
            .o_active  (act),
            .o_pending (o_pending[k])
        );

        assign o_period[16*k +: 16]    = act[FLD_PERIOD];
        assign o_compare_a[16*k +: 16] = act[FLD_CMPA];
        assign o_compare_b[16*k +: 16] = act[FLD_CMPB];
        assign o_phase[16*k +: 16]     = act[FLD_PHASE];
    end

endmodule
